// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs decoded fields into 32-bit words and
// writes them to instruction memory. Optional opcode legality check: ENC_OPCODE_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic              InLast,
    input  logic [5:0]        InOpCode,
    input  logic [4:0]        InRs,
    input  logic [4:0]        InRt,
    input  logic [4:0]        InRd,
    input  logic [15:0]       InImm,
    input  logic [25:0]       InTarget,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    input  logic              MemAck,
    output logic [ADDR_W:0]   WordCount,
    output logic              Done,
    output logic              Full,
    output logic              Error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd2;
    localparam logic [2:0] S_FULL  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [ADDR_W-1:0] BASE_C  = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              op_illegal;
    logic [ADDR_W:0]   count_inc;

    function automatic logic [31:0] encode(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [31:0] w;
        case (op) inside
            6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h0F,
            6'h10, 6'h13, [6'h1A:6'h1D]: w = {op, rs, rt, rd, 11'b0};
            6'h11, 6'h12:                w = {op, tgt};
            default:                     w = {op, rs, rt, imm};
        endcase
        return w;
    endfunction

`ifdef ENC_OPCODE_CHECK_EN
    assign op_illegal = (InOpCode > 6'h21);
`else
    assign op_illegal = 1'b0;
`endif

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    if (op_illegal) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        data_d  = encode(InOpCode, InRs, InRt, InRd, InImm, InTarget);
                        last_d  = InLast;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (MemAck) begin
                    count_d = count_inc;
                    // Hold the address on the final slot so it can never wrap past the top.
                    if (count_inc != DEPTH_C) addr_d = addr_q + 1'b1;
                    if (count_inc == DEPTH_C) full_d = 1'b1;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (count_inc == DEPTH_C) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_C;
            data_q  <= 32'h0;
            count_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign InReady   = (state_q == S_IDLE) && !Reset;
    assign MemWrEn   = (state_q == S_WRITE);
    assign MemAddr   = addr_q;
    assign MemData   = data_q;
    assign WordCount = count_q;
    assign Done      = done_q;
    assign Full      = full_q;
    assign Error     = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (BASE_ADDR=8, DEPTH=4) with an expected-write scoreboard.
module tb_instr_encoder;

    localparam int AW = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic          InLast = 1'b0;
    logic [5:0]    InOpCode = '0;
    logic [4:0]    InRs = '0, InRt = '0, InRd = '0;
    logic [15:0]   InImm = '0;
    logic [25:0]   InTarget = '0;
    logic          MemWrEn;
    logic [AW-1:0] MemAddr;
    logic [31:0]   MemData;
    logic          MemAck = 1'b0;
    logic [AW:0]   WordCount;
    logic          Done, Full, Error;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
    wr_t sb[$];
    int  exp_addr;
    int  exp_count;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(8), .DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InLast(InLast),
        .InOpCode(InOpCode), .InRs(InRs), .InRt(InRt), .InRd(InRd), .InImm(InImm),
        .InTarget(InTarget), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemData(MemData),
        .MemAck(MemAck), .WordCount(WordCount), .Done(Done), .Full(Full), .Error(Error)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b1; InValid = 1'b0; MemAck = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready", {31'b0, InReady}, 32'd0);
        chk("rst_wren", {31'b0, MemWrEn}, 32'd0);
        chk("rst_addr", {24'b0, MemAddr}, 32'd8);
        chk("rst_data", MemData, 32'd0);
        chk("rst_count", {23'b0, WordCount}, 32'd0);
        chk("rst_flags", {29'b0, Done, Full, Error}, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_ready", {31'b0, InReady}, 32'd1);
        sb.delete();
        exp_addr = 8; exp_count = 0;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic last);
        InOpCode = op; InRs = rs; InRt = rt; InRd = rd; InImm = imm; InTarget = tgt;
        InLast = last; InValid = 1'b1;
    endtask

    // Presents one bundle, checks the resulting write, holds off the ack for 'stall' cycles.
    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, input logic [31:0] exp_data, input int stall);
        int  waited;
        wr_t e;
        @(negedge Clk);
        drive(op, rs, rt, rd, imm, tgt, last);
        sb.push_back('{addr: exp_addr[AW-1:0], data: exp_data});
        waited = 0;
        while (!InReady && waited < 10) begin
            @(negedge Clk);
            waited++;
        end
        total++;
        if (!InReady) begin
            bad++;
            $display("FAIL accept_timeout observed=0 expected=1");
            InValid = 1'b0;
            return;
        end
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(negedge Clk);
        e = sb.pop_front();
        chk("wren", {31'b0, MemWrEn}, 32'd1);
        chk("addr", {24'b0, MemAddr}, {24'b0, e.addr});
        chk("data", MemData, e.data);
        for (int i = 0; i < stall; i++) begin
            @(negedge Clk);
            chk("stall_wren", {31'b0, MemWrEn}, 32'd1);
            chk("stall_addr", {24'b0, MemAddr}, {24'b0, e.addr});
            chk("stall_data", MemData, e.data);
            chk("stall_ready", {31'b0, InReady}, 32'd0);
        end
        MemAck = 1'b1;
        @(posedge Clk); #1;
        MemAck = 1'b0;
        $display("txn addr=%0h data=%h", e.addr, e.data);
        exp_count++;
        @(negedge Clk);
        chk("count", {23'b0, WordCount}, exp_count);
        if (exp_count < 4) begin
            exp_addr++;
            chk("next_addr", {24'b0, MemAddr}, exp_addr);
        end
        chk("ack_wren", {31'b0, MemWrEn}, 32'd0);
        chk("ack_ready", {31'b0, InReady}, {31'b0, !(last || exp_count == 4)});
        chk("done", {31'b0, Done}, {31'b0, last});
        chk("full", {31'b0, Full}, {31'b0, exp_count == 4});
    endtask

    initial begin
        exp_addr = 8; exp_count = 0;
        // Basic formats, stalled ack, then fill all four slots.
        do_reset();
        send(6'h00, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h00221800, 0);
        send(6'h01, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0, 1'b0, 32'h0485FFFF, 5);
        send(6'h11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b0, 32'h44000010, 0);
        send(6'h13, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h4FE00000, 1);
        // A fifth bundle must never be accepted.
        @(negedge Clk);
        drive(6'h00, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("full_wren", {31'b0, MemWrEn}, 32'd0);
            chk("full_ready", {31'b0, InReady}, 32'd0);
        end
        chk("full_count", {23'b0, WordCount}, 32'd4);
        InValid = 1'b0;

        // I vs R neighbours; InLast on the second word.
        do_reset();
        send(6'h0E, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0, 1'b0, 32'h38431234, 0);
        send(6'h0F, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b1, 32'h3C210800, 2);
        repeat (3) @(negedge Clk);
        chk("done_sticky", {31'b0, Done}, 32'd1);
        chk("done_count", {23'b0, WordCount}, 32'd2);

        // Reset while a write is pending discards it.
        do_reset();
        @(negedge Clk);
        drive(6'h1A, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0);
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(negedge Clk);
        chk("pend_wren", {31'b0, MemWrEn}, 32'd1);
        chk("pend_data", MemData, 32'h68A63800);
        do_reset();
        send(6'h12, 5'd3, 5'd3, 5'd3, 16'h5555, 26'h3FFFFFF, 1'b0, 32'h4BFFFFFF, 0);

        // Opcode beyond the table.
`ifdef ENC_OPCODE_CHECK_EN
        @(negedge Clk);
        drive(6'h3F, 5'd1, 5'd2, 5'd0, 16'hABCD, 26'h0, 1'b0);
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("err_flag", {31'b0, Error}, 32'd1);
            chk("err_wren", {31'b0, MemWrEn}, 32'd0);
            chk("err_ready", {31'b0, InReady}, 32'd0);
            chk("err_count", {23'b0, WordCount}, 32'd1);
        end
`else
        send(6'h3F, 5'd1, 5'd2, 5'd0, 16'hABCD, 26'h0, 1'b0, 32'hFC22ABCD, 0);
        chk("no_err", {31'b0, Error}, 32'd0);
`endif

        // Last word landing on the final slot sets both Done and Full.
        do_reset();
        send(6'h00, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h00221800, 0);
        send(6'h1A, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0, 32'h68A63800, 0);
        send(6'h0E, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0, 1'b0, 32'h38431234, 0);
        send(6'h11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 32'h44000010, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
